// File: rtl/gpio_pulse_generator_pkg.sv
// Shared definitions for the GPIO pulse generator core: state encoding and
// default sizing.
package gpio_pulse_generator_pkg;

  localparam int GPIO_DATA_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF       = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_HIGH  = 3'd3,
    ST_LOW   = 3'd4
  } state_t;

endpackage

// File: rtl/gpio_tristate_bank.sv
// Per-pin tristate driver: each pin follows out[i] when oe[i] is set,
// otherwise it floats.
module gpio_tristate_bank #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] oe,
  inout  wire  [WIDTH-1:0] pins
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign pins[i] = oe[i] ? out[i] : 1'bz;
  end

endmodule

// File: rtl/gpio_pulse_generator.sv
// Triggered pulse-train generator. Once armed, a rising trigger edge snapshots
// the timing/pin configuration and plays out count pulses on the masked pins.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | arm low; masked pins held at the inactive level
// ST_ARMED | waiting for a trigger edge; config is still live
// ST_DELAY | counting the trigger-to-first-pulse delay
// ST_HIGH  | pulse active on the shadow-masked pins
// ST_LOW   | gap between pulses (skipped after the last pulse)
module gpio_pulse_generator
  import gpio_pulse_generator_pkg::*;
#(
  parameter int GPIO_DATA_WIDTH = GPIO_DATA_WIDTH_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       arm,
  input  logic                       soft_trig,
  input  logic                       ext_trig,
  input  logic [CNT_WIDTH-1:0]       delay,
  input  logic [CNT_WIDTH-1:0]       width,
  input  logic [CNT_WIDTH-1:0]       period,
  input  logic [15:0]                count,
  input  logic [GPIO_DATA_WIDTH-1:0] pin_mask,
  input  logic                       polarity,
  inout  wire  [GPIO_DATA_WIDTH-1:0] gpio_data,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                pulse_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state;
  logic                       soft_r;
  logic                       ext_r;
  logic                       trig_d;
  logic [CNT_WIDTH-1:0]       cnt;
  logic [CNT_WIDTH-1:0]       delay_s;
  logic [CNT_WIDTH-1:0]       width_s;
  logic [CNT_WIDTH-1:0]       period_s;
  logic [15:0]                count_s;
  logic [GPIO_DATA_WIDTH-1:0] mask_s;
  logic                       pol_s;
  logic [GPIO_DATA_WIDTH-1:0] oe_r;
  logic [GPIO_DATA_WIDTH-1:0] out_r;

  logic                       trig_now;
  logic                       trig_edge;
  logic [CNT_WIDTH-1:0]       delay_last;
  logic [CNT_WIDTH-1:0]       high_last;
  logic [CNT_WIDTH-1:0]       low_last;
  logic [15:0]                count_eff;

  assign trig_now  = soft_r | ext_r;
  assign trig_edge = trig_now & ~trig_d;

  // Phase lengths are stored as "last count value" so zero-length settings
  // collapse to a single cycle without any counter wrap.
  assign delay_last = (delay_s == '0) ? '0 : delay_s - CNT_ONE;
  assign high_last  = (width_s == '0) ? '0 : width_s - CNT_ONE;
  assign low_last   = (period_s > width_s) ? (period_s - width_s - CNT_ONE) : '0;
  assign count_eff  = (count_s == 16'd0) ? 16'd1 : count_s;

  // Sequencer: trigger sync, shadow capture, phase counting and registered pin drive.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      soft_r    <= 1'b0;
      ext_r     <= 1'b0;
      trig_d    <= 1'b0;
      cnt       <= '0;
      delay_s   <= '0;
      width_s   <= '0;
      period_s  <= '0;
      count_s   <= '0;
      mask_s    <= '0;
      pol_s     <= 1'b0;
      oe_r      <= '0;
      out_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      soft_r <= soft_trig;
      ext_r  <= ext_trig;
      trig_d <= trig_now;
      done   <= 1'b0;
      if (!arm) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        oe_r  <= pin_mask;
        out_r <= {GPIO_DATA_WIDTH{polarity}};
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ARMED;
            busy  <= 1'b0;
            oe_r  <= pin_mask;
            out_r <= {GPIO_DATA_WIDTH{polarity}};
          end
          ST_ARMED: begin
            oe_r  <= pin_mask;
            out_r <= {GPIO_DATA_WIDTH{polarity}};
            busy  <= 1'b0;
            if (trig_edge) begin
              delay_s  <= delay;
              width_s  <= width;
              period_s <= period;
              count_s  <= count;
              mask_s   <= pin_mask;
              pol_s    <= polarity;
              cnt      <= '0;
              busy     <= 1'b1;
              // A zero delay goes straight to the first pulse.
              if (delay == '0) begin
                state     <= ST_HIGH;
                pulse_cnt <= 16'd1;
                out_r     <= {GPIO_DATA_WIDTH{~polarity}};
              end else begin
                state     <= ST_DELAY;
                pulse_cnt <= 16'd0;
              end
            end
          end
          ST_DELAY: begin
            if (cnt >= delay_last) begin
              state     <= ST_HIGH;
              cnt       <= '0;
              pulse_cnt <= pulse_cnt + 16'd1;
              out_r     <= {GPIO_DATA_WIDTH{~pol_s}};
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (cnt >= high_last) begin
              cnt <= '0;
              if (pulse_cnt >= count_eff) begin
                state <= ST_ARMED;
                done  <= 1'b1;
                busy  <= 1'b0;
                oe_r  <= pin_mask;
                out_r <= {GPIO_DATA_WIDTH{polarity}};
              end else begin
                state <= ST_LOW;
                out_r <= {GPIO_DATA_WIDTH{pol_s}};
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_LOW: begin
            if (cnt >= low_last) begin
              state     <= ST_HIGH;
              cnt       <= '0;
              pulse_cnt <= pulse_cnt + 16'd1;
              out_r     <= {GPIO_DATA_WIDTH{~pol_s}};
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  gpio_tristate_bank #(
    .WIDTH(GPIO_DATA_WIDTH)
  ) u_bank (
    .out  (out_r),
    .oe   (oe_r),
    .pins (gpio_data)
  );

endmodule

// File: doc/gpio_pulse_generator.md
GPIO_PULSE_GENERATOR -- requirements
Module: gpio_pulse_generator

Interface
REQ-001 The block SHALL have parameter GPIO_DATA_WIDTH, default 16: number of GPIO pins.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32: width of the delay, width and period counters.
REQ-003 The block SHALL have port aclk, input, 1 bit: clock.
REQ-004 The block SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port arm, input, 1 bit: level-sensitive enable; low aborts any operation.
REQ-006 The block SHALL have port soft_trig, input, 1 bit: software trigger.
REQ-007 The block SHALL have port ext_trig, input, 1 bit: hardware trigger from the acquisition path.
REQ-008 The block SHALL have port delay, input, CNT_WIDTH bits: cycles from trigger to first pulse.
REQ-009 The block SHALL have port width, input, CNT_WIDTH bits: pulse-high duration in cycles.
REQ-010 The block SHALL have port period, input, CNT_WIDTH bits: pulse start-to-start spacing in cycles.
REQ-011 The block SHALL have port count, input, 16 bits: number of pulses per trigger.
REQ-012 The block SHALL have port pin_mask, input, GPIO_DATA_WIDTH bits: pins driven by the block.
REQ-013 The block SHALL have port polarity, input, 1 bit: 0 = active-high pulses, 1 = active-low pulses.
REQ-014 The block SHALL have port gpio_data, inout, GPIO_DATA_WIDTH bits: external pins.
REQ-015 The block SHALL have port busy, output, 1 bit: high in DELAY, HIGH and LOW.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse after the sequence completes.
REQ-017 The block SHALL have port pulse_cnt, output, 16 bits: pulses emitted since the last trigger.

Function
REQ-018 The FSM SHALL have states IDLE, ARMED, DELAY, HIGH, LOW; arm low in IDLE keeps IDLE; arm high in IDLE moves to ARMED next cycle.
REQ-019 The trigger SHALL be a rising edge of (soft_trig | ext_trig), both inputs registered once; an edge detected in ARMED SHALL latch delay, width, period, count, pin_mask and polarity into shadow registers and enter DELAY.
REQ-020 Trigger edges outside ARMED SHALL be ignored; input config changes while busy SHALL have no effect until the next trigger.
REQ-021 Latency: the first pin assertion SHALL occur exactly delay+1 cycles after the cycle in which the trigger edge is registered; delay=0 gives 1 cycle.
REQ-022 HIGH SHALL last max(width,1) cycles; LOW SHALL last max(period-width,1) cycles, and 1 cycle when period<=width.
REQ-023 count=0 SHALL be treated as 1; pulse_cnt SHALL clear on trigger and increment on each HIGH entry.
REQ-024 After the last HIGH phase the FSM SHALL skip LOW, pulse done for one cycle, and return to ARMED if arm is high, else IDLE.
REQ-025 arm low in any state SHALL force IDLE on the next cycle with pins inactive, busy low, and no done pulse.
REQ-026 Pins with shadow pin_mask=1 SHALL be driven to polarity^pulse_active; pins with mask=0 SHALL be high-Z; in IDLE and ARMED, masked pins SHALL be driven to the inactive level of the live polarity input.
REQ-027 All counter arithmetic SHALL be unsigned CNT_WIDTH bits with no wrap: counters count up from 0 and compare against the shadow target.

Reset
REQ-028 While aresetn is low the block SHALL enter state IDLE, set busy=0, done=0, pulse_cnt=0, clear all counters and shadows, and tri-state all pins.
REQ-029 Reset asserted mid-sequence SHALL override arm and the triggers in the same cycle.

Structure
REQ-030 The state encodings and the default GPIO_DATA_WIDTH SHALL live in the shared header included by the GPIO cores.
REQ-031 Per-pin tristate drive SHALL be a sub-module, gpio_tristate_bank (inputs: out, oe; inout: pins), instantiated once.

Verification
REQ-032 arm=1, delay=3, width=2, period=5, count=3, mask=0x0001, polarity=0, soft_trig edge at cycle T -> pin0 high at T+4..T+5, T+9..T+10, T+14..T+15; done at T+16; pulse_cnt=3.
REQ-033 delay=0, width=0, period=0, count=0 -> a single 1-cycle pulse at T+1, followed by done.
REQ-034 Drop arm during the second HIGH phase -> pin inactive next cycle, state IDLE, no done, pulse_cnt holds 2.
REQ-035 Second ext_trig edge and a width change during DELAY -> both ignored, and the original timing is preserved.
REQ-036 mask=0x8001, polarity=1 -> pins 0 and 15 idle high and pulse low, while pins 1-14 read Z.
REQ-037 aresetn low at the midpoint of LOW -> next cycle all outputs 0 and pins Z; after reset with arm=1 the block reaches ARMED one cycle later.
